// File: rtl/piso_tx_pkg.sv
// Shared definitions for the sipo/piso serial link family.
// State encoding and bit-order selector constants.
package piso_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam bit LSB_FIRST_SEL = 1'b0;
    localparam bit MSB_FIRST_SEL = 1'b1;

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a one-word holding buffer.
// Words stream back-to-back on sout/sen without idle cycles.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter bit          MSB_FIRST = MSB_FIRST_SEL
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         sout,
    output logic         sen,
    output logic         busy,
    output logic         word_done
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LastCnt = CW'(N - 1);

    state_e         state_q, state_d;
    logic [N-1:0]   sreg_q, sreg_d;
    logic [N-1:0]   hbuf_q, hbuf_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           hvalid_q, hvalid_d;

    logic           accept;
    logic           last_bit;
    logic [N-1:0]   sreg_shifted;

    assign accept   = din_valid && !hvalid_q;
    assign last_bit = (state_q == SHIFT) && (cnt_q == LastCnt);

    // Shift toward the output end, filling with zero.
    assign sreg_shifted = MSB_FIRST ? {sreg_q[N-2:0], 1'b0} : {1'b0, sreg_q[N-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            hbuf_q   <= '0;
            cnt_q    <= '0;
            hvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            hbuf_q   <= hbuf_d;
            cnt_q    <= cnt_d;
            hvalid_q <= hvalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        hbuf_d   = hbuf_q;
        cnt_d    = cnt_q;
        hvalid_d = hvalid_q;

        // Acceptance needs an empty buffer and transfer a full one, so they never collide.
        if (accept) begin
            hbuf_d   = din;
            hvalid_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (hvalid_q) begin
                    sreg_d   = hbuf_q;
                    hvalid_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    cnt_d = '0;
                    if (hvalid_q) begin
                        sreg_d   = hbuf_q;
                        hvalid_d = 1'b0;
                    end else begin
                        sreg_d  = sreg_shifted;
                        state_d = IDLE;
                    end
                end else begin
                    sreg_d = sreg_shifted;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sen       = (state_q == SHIFT);
        sout      = 1'b0;
        if (sen) begin
            sout = MSB_FIRST ? sreg_q[N-1] : sreg_q[0];
        end
        word_done = last_bit;
        busy      = sen || hvalid_q;
        din_ready = rst && !hvalid_q;
    end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
Parallel-in serial-out transmitter that sits directly upstream of the sipo register. It accepts N-bit words over a valid/ready handshake and holds them in a one-word buffer. It then shifts each word out one bit per clock on sout, with sen asserted, so it can drive the sipo's sin and load inputs directly. Back-to-back words stream with no idle cycle between them.

Parameters:
N, 4, word width in bits; legal range N >= 2.
MSB_FIRST, 1, 1 = transmit din[N-1] first; 0 = transmit din[0] first.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset.
din  input  N  parallel word to transmit.
din_valid  input  1  din holds a word to be accepted.
din_ready  output  1  holding buffer is empty; word accepted on a rising edge where din_valid && din_ready.
sout  output  1  serial data bit; connects to sipo sin.
sen  output  1  sout carries a valid bit this cycle; connects to sipo load.
busy  output  1  high while in SHIFT or while the holding buffer is full.
word_done  output  1  single-cycle pulse, concurrent with the last bit of each word.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low: rst = 0 forces all state immediately, regardless of clk.
- State: FSM {IDLE, SHIFT}; shift register sreg[N-1:0]; bit counter cnt of width clog2(N); holding buffer hbuf[N-1:0] with flag hvalid.
- Reset values: state IDLE, sreg 0, cnt 0, hbuf 0, hvalid 0. Outputs: sout 0, sen 0, busy 0, word_done 0. din_ready is forced to 0 while rst is low and equals 1 from the first cycle after release.
- din_ready = !hvalid (from registers only; no combinational path from din_valid). On an accepting edge, hbuf <= din and hvalid <= 1.
- IDLE:
  - sen = 0, sout = 0.
  - If hvalid: at the next edge, sreg <= hbuf, hvalid <= 0, cnt <= 0, state -> SHIFT.
  - Latency: word accepted at edge k; first bit appears on sout in the cycle after edge k+1.
- SHIFT:
  - sen = 1.
  - sout = sreg[N-1] if MSB_FIRST, else sreg[0].
  - Each edge: sreg shifts toward the output end with 0 filled in; cnt increments.
- Last bit (cnt == N-1):
  - word_done = 1 this cycle.
  - At the edge, if hvalid: sreg <= hbuf, hvalid <= 0, cnt <= 0, stay in SHIFT (no gap).
  - Otherwise: state -> IDLE, cnt <= 0.
- Sustained throughput: one word per N cycles. The buffer refills during the current shift.
- Acceptance and transfer never occur on the same edge, because acceptance requires hvalid = 0 and transfer requires hvalid = 1.
- din_valid while din_ready = 0: ignored; din may change freely and the buffered word is unaffected.
- busy = (state == SHIFT) || hvalid.
- Reset mid-word: sen and sout drop to 0 immediately. The partial word and the buffered word are discarded, and no word_done is issued.
- sout and sen are combinational decodes of registered state only (glitch-free relative to clk, no input-to-output path).

Decomposition:
- Shared package (sipo/piso family): state encoding constants IDLE = 1'b0, SHIFT = 1'b1; the bit-direction selector constants for MSB_FIRST.
- No sub-module. The buffer, counter and shifter are small enough to live inline.
- Top-level loopback bench instantiates piso_tx feeding sipo (sout -> sin, sen -> load); see scenario 2.

Test Plan:
1. Reset, N=4: hold rst = 0 for 2 cycles with din_valid = 1 -> din_ready = 0, sen = 0, sout = 0, busy = 0, word_done = 0; din_ready = 1 in the first cycle after release.
2. Single word, MSB_FIRST=1: accept din = 4'b1011 -> one cycle later sen = 1 for exactly 4 cycles with sout = 1,0,1,1; word_done high on the 4th cycle only. In the loopback bench, the sipo q = 1011 after the last shift.
3. Back-to-back words: offer 4'b1011 then 4'b0110 with din_valid held high -> 8 contiguous sen cycles, sout = 1,0,1,1,0,1,1,0. din_ready drops while hbuf is full. Two word_done pulses, 4 cycles apart.
4. MSB_FIRST=0, din = 4'b1011 -> sout = 1,1,0,1; word_done on the 4th bit.
5. Mid-word reset: assert rst after 2 bits of 4'b1100 with 4'b0011 buffered -> sen = 0 immediately and busy = 0. After release, a new word 4'b1001 is transmitted as 1,0,0,1, with no bits from the aborted or buffered words.
6. Backpressure: with hbuf full, toggle din (0000, 1111) while din_valid = 1 -> neither value is accepted. Only the word presented when din_ready returns to 1 is transmitted.
